// File: rtl/memory_bus_responder.sv
// memory_bus_responder: far-end target of the core memory bus.
// Holds a word-organised RAM and a CLINT-style timer / software-interrupt unit.
// Reads return the whole aligned word one edge after sampling; writes are
// lane-shifted by the low address bits and committed at the sampling edge.
module memory_bus_responder #(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
  parameter logic [31:0] CLINT_BASE   = 32'h0200_0000,
  parameter int unsigned TIMER_DIVIDE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_bus,
  input  logic [31:0] data_bus_out,
  input  logic [1:0]  data_size,
  input  logic        read,
  input  logic        write,
  output logic [31:0] data_bus_in,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PRE_W  = (TIMER_DIVIDE > 1) ? $clog2(TIMER_DIVIDE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_DIVIDE - 1);

  // CLINT word offsets (byte offset >> 2)
  localparam logic [13:0] OFF_MSIP    = 14'h0000;
  localparam logic [13:0] OFF_CMP_LO  = 14'h1000;
  localparam logic [13:0] OFF_CMP_HI  = 14'h1001;
  localparam logic [13:0] OFF_TIME_LO = 14'h2FFE;
  localparam logic [13:0] OFF_TIME_HI = 14'h2FFF;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = lanes[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return res;
  endfunction

  logic [31:0]       ram_r [RAM_WORDS];
  logic              ram_hit_s;
  logic              clint_hit_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic [13:0]       clint_off_s;
  logic [3:0]        lanes_s;
  logic [31:0]       wdata_s;
  logic              size_ok_s;
  logic              do_write_s;
  logic              do_read_s;
  logic [31:0]       clint_rdata_s;
  logic [31:0]       rdata_s;
  logic              tick_s;
  logic [PRE_W-1:0]  presc_r;
  logic [PRE_W-1:0]  presc_next_s;
  logic [63:0]       mtime_r;
  logic [63:0]       mtime_inc_s;
  logic [63:0]       mtime_next_s;
  logic [63:0]       mtimecmp_r;
  logic [63:0]       mtimecmp_next_s;
  logic              msip_r;
  logic              msip_next_s;
  logic [31:0]       merged_s;
  logic [31:0]       data_bus_in_r;
  logic              timer_int_r;

  assign ram_hit_s   = (address_bus[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
  assign clint_hit_s = (address_bus[31:16] == CLINT_BASE[31:16]);
  assign ram_idx_s   = address_bus[RAM_AW+1:2];
  assign clint_off_s = address_bus[15:2];
  assign do_write_s  = write & size_ok_s;
  assign do_read_s   = read & ~write;
  assign tick_s      = (presc_r == PRE_LAST);

  // Lane enables and replicated write data; misaligned or reserved sizes are rejected.
  always_comb begin
    lanes_s   = 4'b0000;
    wdata_s   = data_bus_out;
    size_ok_s = 1'b0;
    case (data_size)
      2'd0: begin
        lanes_s   = 4'b0001 << address_bus[1:0];
        wdata_s   = {4{data_bus_out[7:0]}};
        size_ok_s = 1'b1;
      end
      2'd1: begin
        lanes_s   = address_bus[1] ? 4'b1100 : 4'b0011;
        wdata_s   = {2{data_bus_out[15:0]}};
        size_ok_s = ~address_bus[0];
      end
      2'd2: begin
        lanes_s   = 4'b1111;
        wdata_s   = data_bus_out;
        size_ok_s = (address_bus[1:0] == 2'b00);
      end
      default: begin
        lanes_s   = 4'b0000;
        wdata_s   = data_bus_out;
        size_ok_s = 1'b0;
      end
    endcase
  end

  // CLINT register read mux; unimplemented offsets read zero.
  always_comb begin
    clint_rdata_s = 32'h0000_0000;
    case (clint_off_s)
      OFF_MSIP:    clint_rdata_s = {31'd0, msip_r};
      OFF_CMP_LO:  clint_rdata_s = mtimecmp_r[31:0];
      OFF_CMP_HI:  clint_rdata_s = mtimecmp_r[63:32];
      OFF_TIME_LO: clint_rdata_s = mtime_r[31:0];
      OFF_TIME_HI: clint_rdata_s = mtime_r[63:32];
      default:     clint_rdata_s = 32'h0000_0000;
    endcase
  end

  // Select the read source by address region; unmapped reads return zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (ram_hit_s) begin
      rdata_s = ram_r[ram_idx_s];
    end else if (clint_hit_s) begin
      rdata_s = clint_rdata_s;
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Prescaler / mtime increment, then overlay any CLINT register write on top.
  always_comb begin
    presc_next_s    = presc_r;
    mtime_inc_s     = mtime_r;
    mtimecmp_next_s = mtimecmp_r;
    msip_next_s     = msip_r;
    merged_s        = 32'h0000_0000;
    if (tick_s) begin
      presc_next_s = '0;
      mtime_inc_s  = mtime_r + 64'd1;
    end else begin
      presc_next_s = presc_r + PRE_W'(1);
      mtime_inc_s  = mtime_r;
    end
    mtime_next_s = mtime_inc_s;
    if (do_write_s && !ram_hit_s && clint_hit_s) begin
      case (clint_off_s)
        OFF_MSIP: begin
          merged_s    = merge_lanes({31'd0, msip_r}, wdata_s, lanes_s);
          msip_next_s = merged_s[0];
        end
        OFF_CMP_LO: begin
          merged_s               = merge_lanes(mtimecmp_r[31:0], wdata_s, lanes_s);
          mtimecmp_next_s[31:0]  = merged_s;
        end
        OFF_CMP_HI: begin
          merged_s               = merge_lanes(mtimecmp_r[63:32], wdata_s, lanes_s);
          mtimecmp_next_s[63:32] = merged_s;
        end
        // unwritten lanes keep the incremented value so a same-cycle tick is not lost
        OFF_TIME_LO: begin
          merged_s            = merge_lanes(mtime_inc_s[31:0], wdata_s, lanes_s);
          mtime_next_s[31:0]  = merged_s;
        end
        OFF_TIME_HI: begin
          merged_s            = merge_lanes(mtime_inc_s[63:32], wdata_s, lanes_s);
          mtime_next_s[63:32] = merged_s;
        end
        default: begin
          merged_s = 32'h0000_0000;
        end
      endcase
    end else begin
      merged_s = 32'h0000_0000;
    end
  end

  // RAM byte-lane write port; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (do_write_s && ram_hit_s) begin
      ram_r[ram_idx_s] <= merge_lanes(ram_r[ram_idx_s], wdata_s, lanes_s);
    end
  end

  // Timer, msip, read-data and interrupt registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_r       <= '0;
      mtime_r       <= 64'd0;
      mtimecmp_r    <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r        <= 1'b0;
      data_bus_in_r <= 32'h0000_0000;
      timer_int_r   <= 1'b0;
    end else begin
      presc_r     <= presc_next_s;
      mtime_r     <= mtime_next_s;
      mtimecmp_r  <= mtimecmp_next_s;
      msip_r      <= msip_next_s;
      timer_int_r <= (mtime_r >= mtimecmp_r);
      if (do_read_s) begin
        data_bus_in_r <= rdata_s;
      end
    end
  end

  assign data_bus_in        = data_bus_in_r;
  assign timer_interrupt    = timer_int_r;
  assign software_interrupt = msip_r;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Testbench for memory_bus_responder: table of bus vectors plus hand-written
// timer / interrupt / reset sequences, read results checked via a scoreboard queue.
module tb_memory_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_bus;
  logic [31:0] data_bus_out;
  logic [1:0]  data_size;
  logic        read;
  logic        write;
  logic [31:0] data_bus_in;
  logic        timer_interrupt;
  logic        software_interrupt;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] CL      = 32'h0200_0000;
  localparam logic [31:0] MSIP    = CL + 32'h0000;
  localparam logic [31:0] CMP_LO  = CL + 32'h4000;
  localparam logic [31:0] CMP_HI  = CL + 32'h4004;
  localparam logic [31:0] TIME_LO = CL + 32'hBFF8;
  localparam logic [31:0] TIME_HI = CL + 32'hBFFC;

  memory_bus_responder dut (
    .clock              (clock),
    .reset              (reset),
    .address_bus        (address_bus),
    .data_bus_out       (data_bus_out),
    .data_size          (data_size),
    .read               (read),
    .write              (write),
    .data_bus_in        (data_bus_in),
    .timer_interrupt    (timer_interrupt),
    .software_interrupt (software_interrupt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [1:0] size, input logic [31:0] exp);
    vq.push_back('{rd, wr, addr, wd, size, exp});
  endtask

  // One bus cycle: drive, clock, then compare read data or the held value.
  task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] size, input logic [31:0] exp);
    logic [31:0] e;
    read         = rd;
    write        = wr;
    address_bus  = addr;
    data_bus_out = wd;
    data_size    = size;
    if (rd && !wr) exp_q.push_back(exp);
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("read_data", data_bus_in, e);
      last_rd = e;
    end else begin
      check("hold_data", data_bus_in, last_rd);
    end
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
  endtask

  initial begin
    reset        = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    address_bus  = 32'h0;
    data_bus_out = 32'h0;
    data_size    = 2'd0;
    last_rd      = 32'h0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_data", data_bus_in, 32'h0);
    check("rst_tint", {31'd0, timer_interrupt}, 32'h0);
    check("rst_sint", {31'd0, software_interrupt}, 32'h0);
    reset = 1'b1;

    // rd, wr, addr, wdata, size, expected read
    add(1'b0, 1'b1, 32'h10,   32'hDEAD_BEEF, 2'd2, 32'h0);
    add(1'b1, 1'b0, 32'h10,   32'h0,         2'd2, 32'hDEAD_BEEF);
    add(1'b0, 1'b1, 32'h12,   32'hFFFF_FF5A, 2'd0, 32'h0);
    add(1'b1, 1'b0, 32'h10,   32'h0,         2'd0, 32'hDE5A_BEEF);
    add(1'b0, 1'b1, 32'h20,   32'h0,         2'd2, 32'h0);
    add(1'b0, 1'b1, 32'h22,   32'hFFFF_1234, 2'd1, 32'h0);
    add(1'b1, 1'b0, 32'h20,   32'h0,         2'd2, 32'h1234_0000);
    add(1'b0, 1'b1, 32'h21,   32'h0000_FFFF, 2'd1, 32'h0);
    add(1'b1, 1'b0, 32'h20,   32'h0,         2'd2, 32'h1234_0000);
    add(1'b0, 1'b1, 32'h13,   32'hFFFF_FFFF, 2'd2, 32'h0);
    add(1'b1, 1'b0, 32'h10,   32'h0,         2'd2, 32'hDE5A_BEEF);
    add(1'b0, 1'b1, 32'h10,   32'h0,         2'd3, 32'h0);
    add(1'b1, 1'b0, 32'h10,   32'h0,         2'd2, 32'hDE5A_BEEF);
    add(1'b0, 1'b1, 32'h10,   32'h0000_ABCD, 2'd1, 32'h0);
    add(1'b0, 1'b1, 32'h13,   32'h0000_0011, 2'd0, 32'h0);
    add(1'b1, 1'b0, 32'h12,   32'h0,         2'd1, 32'h115A_ABCD);
    add(1'b0, 1'b1, 32'h0,    32'h1111_1111, 2'd2, 32'h0);
    add(1'b0, 1'b1, 32'h1000, 32'h7777_7777, 2'd2, 32'h0);
    add(1'b1, 1'b0, 32'h0,    32'h0,         2'd2, 32'h1111_1111);
    add(1'b1, 1'b0, 32'h1000, 32'h0,         2'd2, 32'h0);
    add(1'b0, 1'b1, 32'hFFC,  32'hCAFE_F00D, 2'd2, 32'h0);
    add(1'b1, 1'b0, 32'hFFC,  32'h0,         2'd2, 32'hCAFE_F00D);
    add(1'b1, 1'b0, 32'h1000_0000, 32'h0,    2'd2, 32'h0);
    add(1'b0, 1'b1, CL + 32'h10, 32'h5,      2'd2, 32'h0);
    add(1'b1, 1'b0, CL + 32'h10, 32'h0,      2'd2, 32'h0);
    add(1'b1, 1'b0, CMP_LO,   32'h0,         2'd2, 32'hFFFF_FFFF);
    add(1'b1, 1'b0, CMP_HI,   32'h0,         2'd2, 32'hFFFF_FFFF);
    add(1'b1, 1'b1, 32'h30,   32'h0000_0055, 2'd2, 32'h0);
    add(1'b1, 1'b0, 32'h30,   32'h0,         2'd2, 32'h0000_0055);

    foreach (vq[i]) begin
      do_cycle(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].wd, vq[i].size, vq[i].exp);
    end

    // software interrupt
    do_cycle(1'b0, 1'b1, MSIP, 32'h1, 2'd2, 32'h0);
    check("sint_set", {31'd0, software_interrupt}, 32'h1);
    do_cycle(1'b1, 1'b0, MSIP, 32'h0, 2'd2, 32'h1);
    do_cycle(1'b0, 1'b1, MSIP, 32'hFFFF_FFFE, 2'd2, 32'h0);
    check("sint_clr", {31'd0, software_interrupt}, 32'h0);
    do_cycle(1'b1, 1'b0, MSIP, 32'h0, 2'd2, 32'h0);

    // timer compare: mtime restarted at 0, mtimecmp = 20
    do_cycle(1'b0, 1'b1, CMP_HI, 32'h0, 2'd2, 32'h0);
    do_cycle(1'b0, 1'b1, TIME_LO, 32'h0, 2'd2, 32'h0);
    do_cycle(1'b0, 1'b1, CMP_LO, 32'd20, 2'd2, 32'h0);
    check("tint_k1", {31'd0, timer_interrupt}, 32'h0);
    for (int k = 2; k <= 24; k++) begin
      idle();
      check($sformatf("tint_k%0d", k), {31'd0, timer_interrupt}, (k >= 21) ? 32'h1 : 32'h0);
    end
    do_cycle(1'b1, 1'b0, TIME_LO, 32'h0, 2'd2, 32'd24);
    check("tint_hold", {31'd0, timer_interrupt}, 32'h1);
    do_cycle(1'b0, 1'b1, CMP_LO, 32'hFFFF_FFFF, 2'd2, 32'h0);
    check("tint_commit", {31'd0, timer_interrupt}, 32'h1);
    idle();
    check("tint_fall", {31'd0, timer_interrupt}, 32'h0);

    // carry from low to high word
    do_cycle(1'b0, 1'b1, TIME_LO, 32'hFFFF_FFFF, 2'd2, 32'h0);
    do_cycle(1'b1, 1'b0, TIME_HI, 32'h0, 2'd2, 32'h0);
    do_cycle(1'b1, 1'b0, TIME_HI, 32'h0, 2'd2, 32'h1);
    do_cycle(1'b1, 1'b0, TIME_LO, 32'h0, 2'd2, 32'h1);

    // write to mtime in the same cycle as an increment
    do_cycle(1'b0, 1'b1, TIME_LO, 32'd100, 2'd2, 32'h0);
    do_cycle(1'b1, 1'b0, TIME_LO, 32'h0, 2'd2, 32'd100);
    do_cycle(1'b0, 1'b1, TIME_LO, 32'h0000_00FF, 2'd2, 32'h0);
    do_cycle(1'b0, 1'b1, TIME_LO + 32'h1, 32'h0000_0012, 2'd0, 32'h0);
    do_cycle(1'b1, 1'b0, TIME_LO, 32'h0, 2'd2, 32'h0000_1200);

    // reset mid-count with all outputs non-zero
    do_cycle(1'b0, 1'b1, MSIP, 32'h1, 2'd2, 32'h0);
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 32'h115A_ABCD);
    check("pre_rst_tint", {31'd0, timer_interrupt}, 32'h1);
    check("pre_rst_sint", {31'd0, software_interrupt}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_data", data_bus_in, 32'h0);
    check("mid_rst_tint", {31'd0, timer_interrupt}, 32'h0);
    check("mid_rst_sint", {31'd0, software_interrupt}, 32'h0);
    last_rd = 32'h0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    do_cycle(1'b1, 1'b0, TIME_LO, 32'h0, 2'd2, 32'h0);
    do_cycle(1'b1, 1'b0, TIME_LO, 32'h0, 2'd2, 32'h1);
    do_cycle(1'b1, 1'b0, CMP_LO, 32'h0, 2'd2, 32'hFFFF_FFFF);
    check("post_rst_tint", {31'd0, timer_interrupt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
